// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serial scan controller feeding an external Mealy sequence detector
// Shifts up to eight bits MSB first, after a one-cycle detector clear, and counts hits.
module seq_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [3:0] len,
  input  logic       det_hit,
  output logic       det_din,
  output logic       det_rst,
  output logic       busy,
  output logic       done,
  output logic [3:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLR   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sreg_q, sreg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] len_clamped;

  assign len_clamped = (len > 4'd8) ? 4'd8 : len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sreg_q    <= 8'd0;
      cnt_q     <= 4'd0;
      hit_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start && (len != 4'd0)) begin
          sreg_d    = data_in;
          cnt_d     = len_clamped;
          hit_cnt_d = 4'd0;
          state_d   = CLR;
        end
      end
      CLR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        sreg_d = {sreg_q[6:0], 1'b0};
        cnt_d  = cnt_q - 4'd1;
        if (det_hit) begin
          hit_cnt_d = hit_cnt_q + 4'd1;
        end
        // A zero count can only arise from corruption; leave rather than wrap.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == CLR) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign det_din = (state_q == SHIFT) && sreg_q[7];
  // Gated by rst directly so the detector is held cleared without waiting for a clock.
  assign det_rst = rst && (state_q != CLR);
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - self-checking bench for seq_scan_ctrl with a detector model and scoreboard
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [3:0] len = 4'd0;
  logic       det_hit;
  logic       det_din;
  logic       det_rst;
  logic       busy;
  logic       done;
  logic [3:0] hit_cnt;

  seq_scan_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .len     (len),
    .det_hit (det_hit),
    .det_din (det_din),
    .det_rst (det_rst),
    .busy    (busy),
    .done    (done),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  // Detector: hit when the current bit and the previously shifted bit are both 1.
  logic prev_q;
  always @(posedge clk or negedge det_rst) begin
    if (!det_rst) prev_q <= 1'b0;
    else          prev_q <= det_din;
  end
  assign det_hit = det_din & prev_q;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] exp_hit;
  } vec_t;

  typedef struct {
    logic [3:0] hit;
    int         due;
    int         busy_len;
  } res_t;

  res_t res_q[$];
  logic bit_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   dones_seen = 0;
  logic eb_v;
  res_t r_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      res_q.delete();
      bit_q.delete();
      busy_run <= 0;
    end else begin
      if (busy && det_rst) begin
        if (bit_q.size() == 0) begin
          check("extra_shift_bit", 1, 0);
        end else begin
          eb_v = bit_q.pop_front();
          check("det_din", int'(det_din), int'(eb_v));
        end
      end else begin
        check("det_din_outside_shift", int'(det_din), 0);
      end
      if (busy) busy_run <= busy_run + 1;
      if (done) begin
        dones_seen <= dones_seen + 1;
        if (res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          r_v = res_q.pop_front();
          check("hit_cnt_at_done", int'(hit_cnt), int'(r_v.hit));
          check("done_cycle", cyc, r_v.due);
          check("busy_cycles", busy_run, r_v.busy_len);
          check("busy_in_done", int'(busy), 0);
        end
        busy_run <= 0;
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic [3:0] l_raw,
                          input logic [3:0] h, input int acc);
    int l;
    l = (l_raw > 4'd8) ? 8 : int'(l_raw);
    for (int k = 0; k < l; k++) bit_q.push_back(d[7-k]);
    res_q.push_back('{h, acc + l + 1, l + 1});
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    @(negedge clk);
    start = 1'b1; data_in = v.data; len = v.len;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    if (v.len == 4'd0) begin
      check("len0_busy", int'(busy), 0);
      check("len0_done", int'(done), 0);
      check("len0_hit_hold", int'(hit_cnt), int'(v.exp_hit));
      start = 1'b1;
      @(posedge clk); #1;
      check("len0_busy_again", int'(busy), 0);
      start = 1'b0;
      return;
    end
    push_exp(v.data, v.len, v.exp_hit, acc);
    check("busy_after_accept", int'(busy), 1);
    check("det_rst_in_clr", int'(det_rst), 0);
    // Disturb the inputs mid-scan; none of this may reach the scan in flight.
    @(negedge clk);
    start = 1'b1; data_in = ~v.data; len = 4'($urandom_range(0, 15));
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    @(posedge clk); #1;
    check("hit_cnt_hold", int'(hit_cnt), int'(v.exp_hit));
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[10];
    int   acc;
    int   dn;
    vecs[0] = '{8'b1110_1100, 4'd8,  4'd3};
    vecs[1] = '{8'b1010_1010, 4'd8,  4'd0};
    vecs[2] = '{8'b1111_0000, 4'd3,  4'd2};
    vecs[3] = '{8'hFF,        4'd15, 4'd7};
    vecs[4] = '{8'h00,        4'd0,  4'd7};
    vecs[5] = '{8'h80,        4'd1,  4'd0};
    vecs[6] = '{8'hC0,        4'd2,  4'd1};
    vecs[7] = '{8'h7F,        4'd8,  4'd6};
    vecs[8] = '{8'hFF,        4'd9,  4'd7};
    vecs[9] = '{8'h36,        4'd5,  4'd1};

    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_det_din", int'(det_din), 0);
    check("rst_det_rst", int'(det_rst), 0);
    check("rst_hit_cnt", int'(hit_cnt), 0);
    #12 rst = 1'b1;
    #1 check("run_det_rst", int'(det_rst), 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // start held high through DONE is taken on the first IDLE edge after it
    @(negedge clk);
    start = 1'b1; data_in = 8'hF0; len = 4'd3;
    @(posedge clk); #1;
    acc = cyc;
    push_exp(8'hF0, 4'd3, 4'd2, acc);
    wait_done(20);
    data_in = 8'hC0; len = 4'd2;
    @(posedge clk); #1;
    check("held_start_idle", int'(busy), 0);
    @(posedge clk); #1;
    check("held_start_accept", int'(busy), 1);
    acc = cyc;
    push_exp(8'hC0, 4'd2, 4'd1, acc);
    start = 1'b0;
    wait_done(20);
    @(posedge clk); #1;
    check("held_start_hit", int'(hit_cnt), 1);

    // reset pulse in the middle of SHIFT aborts the scan
    @(negedge clk);
    start = 1'b1; data_in = 8'hFF; len = 4'd8;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    push_exp(8'hFF, 4'd8, 4'd7, acc);
    repeat (4) @(negedge clk);
    dn = dones_seen;
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_det_din", int'(det_din), 0);
    check("midrst_det_rst", int'(det_rst), 0);
    check("midrst_hit_cnt", int'(hit_cnt), 0);
    #14 rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", dones_seen, dn);
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    check("pending_results", res_q.size(), 0);
    check("pending_bits", bit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
